// File: rtl/bcd_dec_pkg.sv
// Shared constants and item type for the BCD one-hot decoder.
package bcd_dec_pkg;

  localparam int unsigned DEC_W = 10;
  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] MAX_CODE = 4'd9;

  typedef struct packed {
    logic [DEC_W-1:0] dec;
    logic             err;
  } dec_item_t;

  localparam dec_item_t ITEM_RESET = '{dec: '0, err: 1'b0};

endpackage

// File: rtl/bcd_dec_skid.sv
// Two-entry ready/valid buffer: output register plus one skid entry.
// in_ready is the registered "skid empty" flag, so out_ready never reaches it combinationally.
module bcd_dec_skid
  import bcd_dec_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  dec_item_t in_item,
  input  logic      in_valid,
  output logic      in_ready,
  output dec_item_t out_item,
  output logic      out_valid,
  input  logic      out_ready
);

  dec_item_t out_q, out_d;
  dec_item_t skid_q, skid_d;
  logic      out_valid_q, out_valid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      accept;
  logic      consume;

  assign accept  = in_valid & ~skid_valid_q;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (consume) begin
      if (skid_valid_q) begin
        // Skid full means in_ready was low, so nothing new is accepted this edge.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_item;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_d       = in_item;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_item;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= ITEM_RESET;
      out_valid_q  <= 1'b0;
      skid_q       <= ITEM_RESET;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_item  = out_q;
  assign out_valid = out_valid_q;

  hold_while_stalled : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_item)));

  no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      (skid_valid_q && !out_ready) |=> skid_valid_q);

endmodule

// File: rtl/bcd_onehot_decoder.sv
// BCD to one-hot decimal decoder with ready/valid handshake on both sides.
// Optional invalid-code counter enabled by defining BCD_DEC_ERRCNT_EN.
module bcd_onehot_decoder
  import bcd_dec_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BCD_W-1:0] in_bcd,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DEC_W-1:0] out_dec,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr
`ifdef BCD_DEC_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  dec_item_t item;
  dec_item_t out_item;

  always_comb begin
    item = ITEM_RESET;
    if (in_bcd <= MAX_CODE) begin
      item.dec = DEC_W'(1) << in_bcd;
    end else begin
      item.err = 1'b1;
    end
  end

  bcd_dec_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_item   (item),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_item  (out_item),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_dec = out_item.dec;
  assign out_err = out_item.err;

`ifdef BCD_DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_inc;

  assign err_inc = in_valid & in_ready & item.err;

  // Clear takes priority over a same-cycle increment; count saturates at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err;
  assign unused_err = ^{err_clr, ERR_CNT_W[0]};
`endif

endmodule

// File: tb/tb_bcd_onehot_decoder.sv
// Directed, table-driven bench for bcd_onehot_decoder (counter checks when BCD_DEC_ERRCNT_EN).
module tb_bcd_onehot_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_bcd;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] out_dec;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       err_clr;
`ifdef BCD_DEC_ERRCNT_EN
  logic [1:0] err_cnt;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [3:0] code;
    logic [9:0] dec;
    logic       err;
    int         cnt;
  } vec_t;

  vec_t vecs[16];

  bcd_onehot_decoder #(
    .ERR_CNT_W (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bcd    (in_bcd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_dec   (out_dec),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr)
`ifdef BCD_DEC_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [9:0] d, input logic e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".out_dec"}, 32'(out_dec), 32'(d));
    check({tag, ".out_err"}, 32'(out_err), 32'(e));
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_bcd    = 4'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;

    vecs[0]  = '{4'd0,  10'b0000000001, 1'b0, 0};
    vecs[1]  = '{4'd1,  10'b0000000010, 1'b0, 0};
    vecs[2]  = '{4'd2,  10'b0000000100, 1'b0, 0};
    vecs[3]  = '{4'd3,  10'b0000001000, 1'b0, 0};
    vecs[4]  = '{4'd4,  10'b0000010000, 1'b0, 0};
    vecs[5]  = '{4'd5,  10'b0000100000, 1'b0, 0};
    vecs[6]  = '{4'd6,  10'b0001000000, 1'b0, 0};
    vecs[7]  = '{4'd7,  10'b0010000000, 1'b0, 0};
    vecs[8]  = '{4'd8,  10'b0100000000, 1'b0, 0};
    vecs[9]  = '{4'd9,  10'b1000000000, 1'b0, 0};
    vecs[10] = '{4'd12, 10'b0000000000, 1'b1, 1};
    vecs[11] = '{4'd10, 10'b0000000000, 1'b1, 2};
    vecs[12] = '{4'd11, 10'b0000000000, 1'b1, 3};
    vecs[13] = '{4'd13, 10'b0000000000, 1'b1, 3};
    vecs[14] = '{4'd14, 10'b0000000000, 1'b1, 3};
    vecs[15] = '{4'd15, 10'b0000000000, 1'b1, 3};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_out("reset", 1'b0, 10'd0, 1'b0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
`ifdef BCD_DEC_ERRCNT_EN
    check("reset.err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    cycle();

    // Back-to-back decode of every code, full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_bcd = vecs[i].code;
      cycle();
      check_out($sformatf("vec%0d", vecs[i].code), 1'b1, vecs[i].dec, vecs[i].err);
      check($sformatf("vec%0d.in_ready", vecs[i].code), 32'(in_ready), 32'd1);
`ifdef BCD_DEC_ERRCNT_EN
      check($sformatf("vec%0d.err_cnt", vecs[i].code), 32'(err_cnt), 32'(vecs[i].cnt));
`endif
    end

    // Clear wins over a same-cycle invalid accept
    in_bcd  = 4'd15;
    err_clr = 1'b1;
    cycle();
    check_out("clr", 1'b1, 10'd0, 1'b1);
`ifdef BCD_DEC_ERRCNT_EN
    check("clr.err_cnt", 32'(err_cnt), 32'd0);
`endif
    err_clr  = 1'b0;
    in_valid = 1'b0;
    cycle();
    check_out("drain", 1'b0, out_dec, out_err);

    // Stall: 3 in output, 4 in skid, 5 waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bcd    = 4'd3;
    cycle();
    check_out("stall3", 1'b1, 10'b0000001000, 1'b0);
    check("stall3.in_ready", 32'(in_ready), 32'd1);
    in_bcd = 4'd4;
    cycle();
    check_out("stall4", 1'b1, 10'b0000001000, 1'b0);
    check("stall4.in_ready", 32'(in_ready), 32'd0);
    in_bcd = 4'd5;
    cycle();
    check_out("stall5", 1'b1, 10'b0000001000, 1'b0);
    check("stall5.in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    cycle();
    check_out("rel4", 1'b1, 10'b0000010000, 1'b0);
    check("rel4.in_ready", 32'(in_ready), 32'd1);
    cycle();
    check_out("rel5", 1'b1, 10'b0000100000, 1'b0);
    in_valid = 1'b0;
    cycle();
    check("rel.empty", 32'(out_valid), 32'd0);

    // Reset with output and skid both full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bcd    = 4'd1;
    cycle();
    in_bcd = 4'd2;
    cycle();
    check("full.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_out("midrst", 1'b0, 10'd0, 1'b0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bcd    = 4'd7;
    cycle();
    check_out("post7", 1'b1, 10'b0010000000, 1'b0);
    in_valid = 1'b0;
    cycle();
    check("post7.empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
